ts_packet_sync: RTL and testbench

Byte-level MPEG-TS packet aligner sitting directly upstream of the transport-stream pass/record/replay state machine. It hunts for the 0x47 sync byte in the raw byte stream, confirms packet periodicity, and once locked forwards bytes with a regenerated, trustworthy sync flag on the first byte of each packet. While unlocked it emits nothing.

---
 rtl/ts_packet_sync.sv | 142 ++++++++++++++
 tb/tb_ts_packet_sync.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_sync.sv
// MPEG-TS byte aligner: hunts for SYNC_BYTE, verifies periodicity, then forwards locked bytes with a regenerated sync flag.
// Define TS_SYNC_ERR_CNT_EN to build the saturating missed-sync counter on SYNC_ERR_CNT.
module ts_packet_sync #(
   parameter int         PKT_LEN    = 188,
   parameter logic [7:0] SYNC_BYTE  = 8'h47,
   parameter int         LOCK_CNT   = 3,
   parameter int         UNLOCK_CNT = 3
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        TS_VALID_IN,
   input  logic [7:0]  TS_DATA_IN,
   output logic        TS_VALID_OUT,
   output logic        TS_SYNC_OUT,
   output logic [7:0]  TS_DATA_OUT,
   output logic        LOCKED,
   output logic [1:0]  STATE,
   output logic [15:0] SYNC_ERR_CNT
);
   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      VERIFY = 2'b01,
      LOCK   = 2'b10
   } state_t;

   localparam logic [7:0] POS_LAST = 8'(PKT_LEN - 1);
   localparam logic [7:0] GOOD_MAX = 8'(LOCK_CNT);
   localparam logic [7:0] MISS_MAX = 8'(UNLOCK_CNT);

   state_t     state, state_nxt;
   logic [7:0] pos, pos_nxt;
   logic [7:0] good, good_nxt;
   logic [7:0] miss, miss_nxt;
   logic [7:0] pos_inc;
   logic       at_sync;
   logic       is_sync;
   logic       fwd;

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      good_nxt  = good;
      miss_nxt  = miss;
      at_sync   = (pos == 8'd0);
      is_sync   = (TS_DATA_IN == SYNC_BYTE);
      pos_inc   = (pos == POS_LAST) ? 8'd0 : pos + 8'd1;
      if (TS_VALID_IN) begin
         case (state)
            HUNT: begin
               if (is_sync) begin
                  state_nxt = VERIFY;
                  pos_nxt   = 8'd1;
                  good_nxt  = 8'd1;
               end
            end
            VERIFY: begin
               if (!at_sync) begin
                  pos_nxt = pos_inc;
               end else if (is_sync) begin
                  pos_nxt  = pos_inc;
                  good_nxt = good + 8'd1;
                  if (good + 8'd1 == GOOD_MAX) begin
                     state_nxt = LOCK;
                     miss_nxt  = 8'd0;
                  end
               end else begin
                  // the mismatching byte is consumed, not re-examined in HUNT
                  state_nxt = HUNT;
                  pos_nxt   = 8'd0;
                  good_nxt  = 8'd0;
               end
            end
            LOCK: begin
               pos_nxt = pos_inc;
               if (at_sync) begin
                  if (is_sync) begin
                     miss_nxt = 8'd0;
                  end else if (miss + 8'd1 == MISS_MAX) begin
                     state_nxt = HUNT;
                     pos_nxt   = 8'd0;
                     good_nxt  = 8'd0;
                     miss_nxt  = 8'd0;
                  end else begin
                     miss_nxt = miss + 8'd1;
                  end
               end
            end
            default: begin
               state_nxt = HUNT;
               pos_nxt   = 8'd0;
               good_nxt  = 8'd0;
               miss_nxt  = 8'd0;
            end
         endcase
      end
   end

   assign fwd = TS_VALID_IN && (state_nxt == LOCK);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state        <= HUNT;
         pos          <= 8'd0;
         good         <= 8'd0;
         miss         <= 8'd0;
         TS_VALID_OUT <= 1'b0;
         TS_SYNC_OUT  <= 1'b0;
         TS_DATA_OUT  <= 8'h00;
      end else begin
         state        <= state_nxt;
         pos          <= pos_nxt;
         good         <= good_nxt;
         miss         <= miss_nxt;
         TS_VALID_OUT <= fwd;
         TS_SYNC_OUT  <= fwd && at_sync;
         if (fwd) TS_DATA_OUT <= TS_DATA_IN;
      end
   end

   assign STATE  = state;
   assign LOCKED = (state == LOCK);

`ifdef TS_SYNC_ERR_CNT_EN
   logic        miss_evt;
   logic [15:0] err_cnt;

   // counts every bad sync slot while locked, including the one that drops lock
   assign miss_evt = TS_VALID_IN && (state == LOCK) && at_sync && !is_sync;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         err_cnt <= 16'h0000;
      else if (miss_evt && (err_cnt != 16'hFFFF))
         err_cnt <= err_cnt + 16'd1;
   end

   assign SYNC_ERR_CNT = err_cnt;
`else
   assign SYNC_ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ts_packet_sync.sv
// Randomized bench for ts_packet_sync against a valid-byte-index reference model, plus literal checkpoints.
module tb_ts_packet_sync;
   localparam int         PKT  = 188;
   localparam int         LCK  = 3;
   localparam int         ULK  = 3;
   localparam logic [7:0] SYNC = 8'h47;

   logic        clk = 1'b0;
   logic        rst;
   logic        vin;
   logic [7:0]  din;
   logic        vout;
   logic        sout;
   logic [7:0]  dout;
   logic        lkd;
   logic [1:0]  st;
   logic [15:0] ecnt;

   always #5 clk = ~clk;

   ts_packet_sync #(.PKT_LEN(PKT), .SYNC_BYTE(SYNC), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK)) dut (
      .CLOCK(clk), .RESET(rst), .TS_VALID_IN(vin), .TS_DATA_IN(din),
      .TS_VALID_OUT(vout), .TS_SYNC_OUT(sout), .TS_DATA_OUT(dout),
      .LOCKED(lkd), .STATE(st), .SYNC_ERR_CNT(ecnt)
   );

   int total = 0;
   int bad   = 0;

   // model: mode 0 hunt / 1 verify / 2 locked; packet phase = (valid index - anchor) mod PKT
   int         m_mode, m_k, m_anchor, m_hits, m_miss, m_err;
   logic       e_vld, e_sync;
   logic [7:0] e_dat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_err();
`ifdef TS_SYNC_ERR_CNT_EN
      return m_err;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_k = 0; m_anchor = 0; m_hits = 0; m_miss = 0; m_err = 0;
      e_vld = 1'b0; e_sync = 1'b0; e_dat = 8'h00;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d);
      bit at;
      e_vld  = 1'b0;
      e_sync = 1'b0;
      if (v) begin
         at = (m_mode == 0) || (((m_k - m_anchor) % PKT) == 0);
         case (m_mode)
            0: if (d == SYNC) begin m_anchor = m_k; m_hits = 1; m_mode = 1; end
            1: if (at) begin
                  if (d == SYNC) begin
                     m_hits++;
                     if (m_hits == LCK) begin m_mode = 2; m_miss = 0; end
                  end else m_mode = 0;
               end
            default: if (at) begin
                  if (d == SYNC) m_miss = 0;
                  else begin
                     m_miss++;
                     if (m_err < 65535) m_err++;
                     if (m_miss == ULK) m_mode = 0;
                  end
               end
         endcase
         m_k++;
         if (m_mode == 2) begin e_vld = 1'b1; e_sync = at; e_dat = d; end
      end
   endtask

   always @(negedge clk) begin
      chk("vld",    {31'd0, vout}, {31'd0, e_vld});
      chk("sync",   {31'd0, sout}, {31'd0, e_sync});
      chk("data",   {24'd0, dout}, {24'd0, e_dat});
      chk("state",  {30'd0, st},   m_mode);
      chk("locked", {31'd0, lkd},  {31'd0, (m_mode == 2)});
      chk("errcnt", {16'd0, ecnt}, exp_err());
   end

   // called one time unit after a rising edge; returns at the same phase
   task automatic send(input logic [7:0] d, input int gap);
      for (int g = 0; g < gap; g++) begin
         vin = 1'b0; din = 8'($urandom);
         @(posedge clk); model_step(1'b0, 8'h00); #1;
      end
      vin = 1'b1; din = d;
      @(posedge clk); model_step(1'b1, d); #1;
      vin = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; vin = 1'b0; model_reset();
      #1;
      chk("rst_vld",  {31'd0, vout}, 0);
      chk("rst_sync", {31'd0, sout}, 0);
      chk("rst_data", {24'd0, dout}, 0);
      chk("rst_state", {30'd0, st},  0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic logic [7:0] sbyte(input int i, input int start);
      logic [7:0] b;
      if (i >= start && ((i - start) % PKT) == 0) return SYNC;
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      return b;
   endfunction

   initial begin
      logic [7:0] d;
      int start;
      rst = 1'b1; vin = 1'b0; din = 8'h00; model_reset();
      @(posedge clk); #1;
      do_reset();
      chk("reset_locked", {31'd0, lkd}, 0);
      chk("reset_err",    {16'd0, ecnt}, 0);

      // clean stream, then a single corrupted sync at 752
      for (int i = 0; i < 1128; i++) begin
         d = sbyte(i, 0);
         if (i == 752) d = 8'h00;
         send(d, 0);
         if (i == 0)   chk("verify_after_0", {30'd0, st}, 1);
         if (i == 375) chk("no_out_375", {31'd0, vout}, 0);
         if (i == 376) begin
            chk("lock_376", {31'd0, lkd}, 1);
            chk("vld_376",  {31'd0, vout}, 1);
            chk("sync_376", {31'd0, sout}, 1);
            chk("data_376", {24'd0, dout}, 32'h47);
         end
         if (i == 564) chk("sync_564", {31'd0, sout}, 1);
         if (i == 565) chk("nosync_565", {31'd0, sout}, 0);
         if (i == 752) begin
            chk("fly_locked", {31'd0, lkd}, 1);
            chk("fly_sync",   {31'd0, sout}, 1);
            chk("fly_data",   {24'd0, dout}, 0);
`ifdef TS_SYNC_ERR_CNT_EN
            chk("fly_err", {16'd0, ecnt}, 1);
`else
            chk("fly_err", {16'd0, ecnt}, 0);
`endif
         end
      end

      // three consecutive bad syncs drop lock
      do_reset();
      for (int i = 0; i < 1200; i++) begin
         d = sbyte(i, 0);
         if (i == 564 || i == 752 || i == 940) d = 8'h00;
         send(d, 0);
         if (i == 940) begin
            chk("unlock_state", {30'd0, st}, 0);
            chk("unlock_vld",   {31'd0, vout}, 0);
`ifdef TS_SYNC_ERR_CNT_EN
            chk("unlock_err", {16'd0, ecnt}, 3);
`else
            chk("unlock_err", {16'd0, ecnt}, 0);
`endif
         end
         if (i == 941) chk("unlock_vld_after", {31'd0, vout}, 0);
      end

      // false sync at 50, true packets from 100
      do_reset();
      for (int i = 0; i < 700; i++) begin
         d = sbyte(i, 100);
         if (i == 50) d = SYNC;
         send(d, 0);
         if (i == 50)  chk("false_verify", {30'd0, st}, 1);
         if (i == 238) chk("false_rehunt", {30'd0, st}, 0);
         if (i == 476) chk("rehunt_verify", {30'd0, st}, 1);
         if (i == 663) chk("prelock_663", {31'd0, lkd}, 0);
         if (i == 664) begin
            chk("lock_664", {31'd0, lkd}, 1);
            chk("lock_664_sync", {31'd0, sout}, 1);
         end
      end

      // lock, then every other cycle idle; then reset mid-packet and relock
      do_reset();
      for (int i = 0; i < 1219; i++) begin
         send(sbyte(i, 0), (i > 377) ? 1 : 0);
         if (i == 564) chk("gap_sync_564", {31'd0, sout}, 1);
      end
      do_reset();
      for (int i = 1219; i < 1700; i++) begin
         send(sbyte(i, 0), 0);
         if (i == 1691) chk("relock_pre", {31'd0, lkd}, 0);
         if (i == 1692) chk("relock", {31'd0, lkd}, 1);
      end

      // randomized: random phase, corrupted syncs, spurious syncs, random gaps
      do_reset();
      start = $urandom_range(0, PKT - 1);
      for (int i = 0; i < 4000; i++) begin
         d = sbyte(i, start);
         if (d == SYNC && $urandom_range(0, 9) == 0) d = 8'($urandom_range(0, 255));
         else if (d != SYNC && $urandom_range(0, 199) == 0) d = SYNC;
         send(d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
